jt12_acc_sched: RTL and testbench

//  Slot sequencer and configuration holder for the FM channel accumulator.

---
 rtl/jt12_acc_sched_pkg.sv | 43 ++++
 rtl/jt12_sched_dly.sv | 39 +++
 rtl/jt12_acc_sched.sv | 144 ++++++++++++++
 tb/tb_jt12_acc_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_acc_sched_pkg.sv
// Shared constants, slot bus layout and slot decode helpers for the
// FM accumulator slot sequencer.
package jt12_acc_sched_pkg;

    localparam int unsigned NUM_CH   = 6;
    localparam int unsigned NUM_SLOT = 24;

    localparam logic [2:0] RST_ALG = 3'd0;
    localparam logic [1:0] RST_RL  = 2'b11;

    // Operator groups in the order they occupy the round (slot / 6).
    typedef enum logic [1:0] {
        GRP_S1 = 2'd0,
        GRP_S3 = 2'd1,
        GRP_S2 = 2'd2,
        GRP_S4 = 2'd3
    } group_t;

    typedef struct packed {
        logic       zero;
        logic       s1;
        logic       s3;
        logic       s2;
        logic       s4;
        logic       ch6op;
        logic [2:0] cur_ch;
        logic [2:0] alg;
        logic [1:0] rl;
        logic       channel_en;
        logic       pcm_en;
    } slot_t;

    localparam int unsigned SLOT_W = $bits(slot_t);

    function automatic logic [2:0] slot_ch(input logic [4:0] s);
        return 3'(s % 5'd6);
    endfunction

    function automatic group_t slot_group(input logic [4:0] s);
        return group_t'(2'(s / 5'd6));
    endfunction

endpackage

// File: rtl/jt12_sched_dly.sv
// Width-parameterised shift register with clock enable and async clear;
// DEPTH=0 is a plain wire.
module jt12_sched_dly #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clk_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, clk_en};
            assign dout = din;
        end else begin : g_shift
            logic [W-1:0] sr [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        sr[i] <= '0;
                    end
                end else if (clk_en) begin
                    sr[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/jt12_acc_sched.sv
// Slot sequencer for the FM channel accumulator: walks the 24 operator slots
// and holds per-channel alg/rl/mute, committing CPU writes only at round wrap.
module jt12_acc_sched
    import jt12_acc_sched_pkg::*;
#(
    parameter int unsigned PIPE_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [1:0] cfg_rl,
    input  logic       cfg_mute,
    input  logic       pcm_en_in,
    output logic       cfg_busy,
    output logic       zero,
    output logic       s1_enters,
    output logic       s3_enters,
    output logic       s2_enters,
    output logic       s4_enters,
    output logic       ch6op,
    output logic [2:0] cur_ch,
    output logic [2:0] alg,
    output logic [1:0] rl,
    output logic       channel_en,
    output logic       pcm_en
);

    logic [4:0] slot_q;
    logic       wrap;
    logic       accept;
    logic [2:0] ch;

    logic [2:0]        alg_bank [NUM_CH];
    logic [1:0]        rl_bank  [NUM_CH];
    logic [NUM_CH-1:0] mute_bank;
    logic              pcm_q;

    logic       busy_q;
    logic [2:0] pend_ch;
    logic [2:0] pend_alg;
    logic [1:0] pend_rl;
    logic       pend_mute;
    logic       pend_pcm;

    slot_t dec_d, dec_q, pres;

    assign wrap   = (slot_q == 5'(NUM_SLOT - 1));
    assign accept = cfg_we & ~busy_q & (cfg_ch < 3'(NUM_CH));
    assign ch     = slot_ch(slot_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else if (clk_en) begin
            slot_q <= wrap ? '0 : slot_q + 5'd1;
        end
    end

    // Commit and capture are exclusive: capture needs ~busy, commit needs busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            pend_ch   <= '0;
            pend_alg  <= '0;
            pend_rl   <= '0;
            pend_mute <= 1'b0;
            pend_pcm  <= 1'b0;
            pcm_q     <= 1'b0;
            mute_bank <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                alg_bank[i] <= RST_ALG;
                rl_bank[i]  <= RST_RL;
            end
        end else if (clk_en) begin
            if (wrap && busy_q) begin
                alg_bank[pend_ch]  <= pend_alg;
                rl_bank[pend_ch]   <= pend_rl;
                mute_bank[pend_ch] <= pend_mute;
                pcm_q              <= pend_pcm;
                busy_q             <= 1'b0;
            end else if (accept) begin
                pend_ch   <= cfg_ch;
                pend_alg  <= cfg_alg;
                pend_rl   <= cfg_rl;
                pend_mute <= cfg_mute;
                pend_pcm  <= pcm_en_in;
                busy_q    <= 1'b1;
            end
        end
    end

    always_comb begin
        dec_d        = '0;
        dec_d.zero   = (slot_q == '0);
        unique case (slot_group(slot_q))
            GRP_S1: dec_d.s1 = 1'b1;
            GRP_S3: dec_d.s3 = 1'b1;
            GRP_S2: dec_d.s2 = 1'b1;
            GRP_S4: dec_d.s4 = 1'b1;
        endcase
        dec_d.ch6op      = (ch == 3'(NUM_CH - 1));
        dec_d.cur_ch     = ch;
        dec_d.alg        = alg_bank[ch];
        dec_d.rl         = rl_bank[ch];
        dec_d.channel_en = ~mute_bank[ch];
        dec_d.pcm_en     = pcm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= '0;
        end else if (clk_en) begin
            dec_q <= dec_d;
        end
    end

    jt12_sched_dly #(
        .DEPTH (PIPE_DLY),
        .W     (SLOT_W)
    ) u_dly (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .din    (dec_q),
        .dout   (pres)
    );

    assign cfg_busy   = busy_q;
    assign zero       = pres.zero;
    assign s1_enters  = pres.s1;
    assign s3_enters  = pres.s3;
    assign s2_enters  = pres.s2;
    assign s4_enters  = pres.s4;
    assign ch6op      = pres.ch6op;
    assign cur_ch     = pres.cur_ch;
    assign alg        = pres.alg;
    assign rl         = pres.rl;
    assign channel_en = pres.channel_en;
    assign pcm_en     = pres.pcm_en;

endmodule

// File: tb/tb_jt12_acc_sched.sv
// Directed bench for jt12_acc_sched with PIPE_DLY=2: slot timing table plus
// hand-written config commit, drop, mute/PCM, clk_en gating and reset sequences.
module tb_jt12_acc_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [2:0] cfg_alg = '0;
    logic [1:0] cfg_rl = '0;
    logic       cfg_mute = 1'b0;
    logic       pcm_en_in = 1'b0;
    logic       cfg_busy, zero, s1_enters, s3_enters, s2_enters, s4_enters, ch6op;
    logic [2:0] cur_ch, alg;
    logic [1:0] rl;
    logic       channel_en, pcm_en;

    int errors = 0;
    int checks = 0;
    int n = 0;

    jt12_acc_sched #(.PIPE_DLY(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_alg    (cfg_alg),
        .cfg_rl     (cfg_rl),
        .cfg_mute   (cfg_mute),
        .pcm_en_in  (pcm_en_in),
        .cfg_busy   (cfg_busy),
        .zero       (zero),
        .s1_enters  (s1_enters),
        .s3_enters  (s3_enters),
        .s2_enters  (s2_enters),
        .s4_enters  (s4_enters),
        .ch6op      (ch6op),
        .cur_ch     (cur_ch),
        .alg        (alg),
        .rl         (rl),
        .channel_en (channel_en),
        .pcm_en     (pcm_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       n;
        bit       zero, s1, s3, s2, s4, ch6op;
        bit [2:0] ch;
        bit [2:0] alg;
        bit [1:0] rl;
        bit       en, pcm;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [15:0] outs();
        return {zero, s1_enters, s3_enters, s2_enters, s4_enters, ch6op,
                cur_ch, alg, rl, channel_en, pcm_en};
    endfunction

    function automatic logic [15:0] slot_exp(input int p, input logic [2:0] a,
                                             input logic [1:0] r, input bit e, input bit pc);
        int g;
        int c;
        g = p / 6;
        c = p % 6;
        return {(p == 0), (g == 0), (g == 1), (g == 2), (g == 3), (c == 5),
                3'(c), a, r, e, pc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (clk_en && rst_n) n++;
        #1;
    endtask

    task automatic goto_slot(input int r);
        while (n % 24 != r) tick();
    endtask

    task automatic write_cfg(input logic [2:0] c, input logic [2:0] a, input logic [1:0] r,
                             input logic m, input logic pc);
        cfg_we = 1'b1; cfg_ch = c; cfg_alg = a; cfg_rl = r; cfg_mute = m; pcm_en_in = pc;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        //            n   zero s1 s3 s2 s4 c6 ch  alg rl  en pcm
        vecs[0]  = '{ 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 0, 0};
        vecs[1]  = '{ 2, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 2'd0, 0, 0};
        vecs[2]  = '{ 3, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'd3, 1, 0};
        vecs[3]  = '{ 8, 0, 1, 0, 0, 0, 1, 3'd5, 3'd0, 2'd3, 1, 0};
        vecs[4]  = '{ 9, 0, 0, 1, 0, 0, 0, 3'd0, 3'd0, 2'd3, 1, 0};
        vecs[5]  = '{10, 0, 0, 1, 0, 0, 0, 3'd1, 3'd0, 2'd3, 1, 0};
        vecs[6]  = '{14, 0, 0, 1, 0, 0, 1, 3'd5, 3'd0, 2'd3, 1, 0};
        vecs[7]  = '{15, 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 2'd3, 1, 0};
        vecs[8]  = '{20, 0, 0, 0, 1, 0, 1, 3'd5, 3'd0, 2'd3, 1, 0};
        vecs[9]  = '{21, 0, 0, 0, 0, 1, 0, 3'd0, 3'd0, 2'd3, 1, 0};
        vecs[10] = '{26, 0, 0, 0, 0, 1, 1, 3'd5, 3'd0, 2'd3, 1, 0};
        vecs[11] = '{27, 1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 2'd3, 1, 0};

        // Reset state, then clk_en low must not advance anything.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_busy", 32'(cfg_busy), 32'h0);
        #3 rst_n = 1'b1;
        repeat (3) tick();
        chk("hold_outs", 32'(outs()), 32'h0);
        clk_en = 1'b1;
        n = 0;

        foreach (vecs[i]) begin
            while (n < vecs[i].n) tick();
            chk($sformatf("vec_n%0d", vecs[i].n), 32'(outs()),
                32'({vecs[i].zero, vecs[i].s1, vecs[i].s3, vecs[i].s2, vecs[i].s4,
                     vecs[i].ch6op, vecs[i].ch, vecs[i].alg, vecs[i].rl,
                     vecs[i].en, vecs[i].pcm}));
        end

        // Second round: zero / s3 / ch6op decode follow the presented slot.
        repeat (25) begin
            int p;
            tick();
            p = (n - 3) % 24;
            chk("scan_zero", 32'(zero), 32'(p == 0));
            chk("scan_s3", 32'(s3_enters), 32'(p >= 6 && p <= 11));
            chk("scan_ch6op", 32'(ch6op), 32'(p % 6 == 5));
        end

        // Write ch2 at counter 10: deferred to wrap.
        goto_slot(10);
        write_cfg(3'd2, 3'd7, 2'b01, 1'b0, 1'b0);
        chk("busy_after_wr", 32'(cfg_busy), 32'h1);
        chk("old_slot8", 32'(outs()), 32'(slot_exp(8, 3'd0, 2'b11, 1, 0)));
        // Write while busy is dropped.
        goto_slot(14);
        write_cfg(3'd3, 3'd5, 2'b10, 1'b0, 1'b0);
        chk("busy_drop", 32'(cfg_busy), 32'h1);
        goto_slot(23);
        chk("busy_pre_wrap", 32'(cfg_busy), 32'h1);
        chk("old_slot20", 32'(outs()), 32'(slot_exp(20, 3'd0, 2'b11, 1, 0)));
        tick();
        chk("busy_wrap_clr", 32'(cfg_busy), 32'h0);
        goto_slot(5);
        chk("new_slot2", 32'(outs()), 32'(slot_exp(2, 3'd7, 2'b01, 1, 0)));
        tick();
        chk("drop_slot3", 32'(outs()), 32'(slot_exp(3, 3'd0, 2'b11, 1, 0)));

        // Out-of-range channel is ignored.
        write_cfg(3'd6, 3'd1, 2'b00, 1'b1, 1'b1);
        chk("busy_ch6", 32'(cfg_busy), 32'h0);
        write_cfg(3'd7, 3'd1, 2'b00, 1'b1, 1'b1);
        chk("busy_ch7", 32'(cfg_busy), 32'h0);
        goto_slot(0);
        goto_slot(5);
        chk("ch6_slot2", 32'(outs()), 32'(slot_exp(2, 3'd7, 2'b01, 1, 0)));
        goto_slot(8);
        chk("ch6_slot5", 32'(outs()), 32'(slot_exp(5, 3'd0, 2'b11, 1, 0)));

        // Mute ch5 with PCM enable.
        goto_slot(12);
        write_cfg(3'd5, 3'd0, 2'b11, 1'b1, 1'b1);
        goto_slot(14);
        chk("pre_mute_s11", 32'(outs()), 32'(slot_exp(11, 3'd0, 2'b11, 1, 0)));
        goto_slot(7);
        chk("pcm_slot4", 32'(outs()), 32'(slot_exp(4, 3'd0, 2'b11, 1, 1)));
        goto_slot(8);
        chk("mute_slot5", 32'(outs()), 32'(slot_exp(5, 3'd0, 2'b11, 0, 1)));
        goto_slot(14);
        chk("mute_slot11", 32'(outs()), 32'(slot_exp(11, 3'd0, 2'b11, 0, 1)));
        goto_slot(20);
        chk("mute_slot17", 32'(outs()), 32'(slot_exp(17, 3'd0, 2'b11, 0, 1)));
        goto_slot(2);
        chk("mute_slot23", 32'(outs()), 32'(slot_exp(23, 3'd0, 2'b11, 0, 1)));

        // clk_en one tick in three: outputs follow enabled ticks and hold otherwise.
        for (int i = 0; i < 100; i++) begin
            int p;
            int c;
            clk_en = (i % 3 == 0);
            tick();
            p = (n - 3) % 24;
            c = p % 6;
            chk("gated_outs", 32'(outs()),
                32'(slot_exp(p, (c == 2) ? 3'd7 : 3'd0, (c == 2) ? 2'b01 : 2'b11, c != 5, 1)));
        end
        clk_en = 1'b1;

        // Reset while a write is pending.
        goto_slot(5);
        write_cfg(3'd1, 3'd3, 2'b10, 1'b1, 1'b0);
        chk("busy_pre_rst", 32'(cfg_busy), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(cfg_busy), 32'h0);
        chk("rst_outs", 32'(outs()), 32'h0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        n = 0;
        while (n < 4) tick();
        chk("rst_slot1", 32'(outs()), 32'(slot_exp(1, 3'd0, 2'b11, 1, 0)));
        tick();
        chk("rst_slot2", 32'(outs()), 32'(slot_exp(2, 3'd0, 2'b11, 1, 0)));
        while (n < 8) tick();
        chk("rst_slot5", 32'(outs()), 32'(slot_exp(5, 3'd0, 2'b11, 1, 0)));
        while (n < 27) tick();
        chk("rst_no_commit", 32'(outs()), 32'(slot_exp(0, 3'd0, 2'b11, 1, 0)));
        chk("rst_busy_end", 32'(cfg_busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
